// File: rtl/pattern_stream_gen.sv
// AXI-Stream pattern source: fixed-length packets of incrementing words with
// a configurable idle gap between them. Every output comes straight from a flop.
module pattern_stream_gen #(
  parameter int DATA_W  = 32,
  parameter int PKT_LEN = 16,
  parameter int GAP     = 4
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              en,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [15:0]       pkt_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAPW
  } state_t;

  localparam logic [15:0] LAST_IDX   = 16'(PKT_LEN - 1);
  localparam logic [7:0]  GAP_LOAD   = 8'(GAP - 1);
  localparam logic        FIRST_LAST = (PKT_LEN == 1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] word_reg, word_next;
  logic [15:0]       beat_reg, beat_next;
  logic [7:0]        gap_reg, gap_next;
  logic [15:0]       pkt_reg, pkt_next;
  logic              valid_reg, valid_next;
  logic              last_reg, last_next;
  logic              busy_reg;
  logic              accept;

  assign accept = valid_reg & m_axis_tready;

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    beat_next  = beat_reg;
    gap_next   = gap_reg;
    pkt_next   = pkt_reg;
    valid_next = valid_reg;
    last_next  = last_reg;

    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = SEND;
          valid_next = 1'b1;
          beat_next  = 16'd0;
          last_next  = FIRST_LAST;
        end
      end

      SEND: begin
        // Without an accept everything holds, so a stalled beat stays put.
        if (accept) begin
          word_next = word_reg + 1'b1;
          if (last_reg) begin
            pkt_next  = pkt_reg + 16'd1;
            beat_next = 16'd0;
            if (GAP > 0) begin
              state_next = GAPW;
              valid_next = 1'b0;
              last_next  = 1'b0;
              gap_next   = GAP_LOAD;
            end else if (en) begin
              valid_next = 1'b1;
              last_next  = FIRST_LAST;
            end else begin
              state_next = IDLE;
              valid_next = 1'b0;
              last_next  = 1'b0;
            end
          end else begin
            beat_next = beat_reg + 16'd1;
            last_next = ((beat_reg + 16'd1) == LAST_IDX);
          end
        end
      end

      GAPW: begin
        // gap_reg counts GAP-1 down to 0, giving exactly GAP idle cycles.
        if (gap_reg == 8'd0) begin
          if (en) begin
            state_next = SEND;
            valid_next = 1'b1;
            last_next  = FIRST_LAST;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_next = gap_reg - 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      beat_reg  <= 16'd0;
      gap_reg   <= 8'd0;
      pkt_reg   <= 16'd0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      beat_reg  <= beat_next;
      gap_reg   <= gap_next;
      pkt_reg   <= pkt_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign m_axis_tdata  = word_reg;
  assign m_axis_tvalid = valid_reg;
  assign m_axis_tlast  = last_reg;
  assign pkt_cnt       = pkt_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Directed bench for pattern_stream_gen: three instances cover the default
// configuration, the GAP=0/PKT_LEN=1 back-to-back case and an 8-bit word wrap.
module tb_pattern_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_word;

  // Instance 0: defaults (DATA_W=32, PKT_LEN=16, GAP=4)
  logic        res_n0, en0, tready0, tvalid0, tlast0, busy0;
  logic [31:0] tdata0;
  logic [15:0] pkt_cnt0;

  // Instance 1: GAP=0, PKT_LEN=1
  logic        res_n1, en1, tready1, tvalid1, tlast1, busy1;
  logic [31:0] tdata1;
  logic [15:0] pkt_cnt1;

  // Instance 2: DATA_W=8
  logic        res_n2, en2, tready2, tvalid2, tlast2, busy2;
  logic [7:0]  tdata2;
  logic [15:0] pkt_cnt2;

  pattern_stream_gen dut0 (
    .clk(clk), .res_n(res_n0), .en(en0),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
    .m_axis_tlast(tlast0), .pkt_cnt(pkt_cnt0), .busy(busy0)
  );

  pattern_stream_gen #(.DATA_W(32), .PKT_LEN(1), .GAP(0)) dut1 (
    .clk(clk), .res_n(res_n1), .en(en1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
    .m_axis_tlast(tlast1), .pkt_cnt(pkt_cnt1), .busy(busy1)
  );

  pattern_stream_gen #(.DATA_W(8)) dut2 (
    .clk(clk), .res_n(res_n2), .en(en2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
    .m_axis_tlast(tlast2), .pkt_cnt(pkt_cnt2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset0();
    res_n0 = 1'b0;
    en0 = 1'b0;
    tready0 = 1'b1;
    repeat (3) @(negedge clk);
    res_n0 = 1'b1;
  endtask

  // Drives instance 0 until stop_at words have been accepted. Every valid
  // cycle must show the next expected word; tready is driven at the negedge,
  // so tvalid && tready here means the upcoming edge accepts the beat.
  task automatic stream0(input int max_cycles, input bit toggle, input int en_off_at, input int stop_at);
    bit done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      tready0 = toggle ? ~tready0 : 1'b1;
      if (tvalid0) begin
        check("s0_data", 64'(tdata0), 64'(exp_word));
        if (tready0) begin
          check("s0_last", 64'(tlast0), 64'((exp_word % 16) == 15));
          if (exp_word == en_off_at) en0 = 1'b0;
          exp_word++;
          if (exp_word == stop_at) done = 1'b1;
        end
      end
    end
    if (!done) check("s0_timeout", 64'(exp_word), 64'(stop_at));
  endtask

  initial begin
    res_n0 = 1'b0; en0 = 1'b0; tready0 = 1'b1;
    res_n1 = 1'b0; en1 = 1'b0; tready1 = 1'b1;
    res_n2 = 1'b0; en2 = 1'b0; tready2 = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_tvalid", 64'(tvalid0), 64'd0);
    check("rst_tdata", 64'(tdata0), 64'd0);
    check("rst_tlast", 64'(tlast0), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);

    // en held high during reset must not start a packet.
    en0 = 1'b1;
    @(negedge clk);
    check("rst_prio_tvalid", 64'(tvalid0), 64'd0);
    $display("[TB] reset state checked");

    // Basic: words 0..15, four idle cycles, then 16..31.
    res_n0 = 1'b1;
    exp_word = 0;
    stream0(100, 1'b0, -1, 16);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check("gap_tvalid", 64'(tvalid0), 64'd0);
      check("gap_busy", 64'(busy0), 64'd1);
      check("gap_pkt_cnt", 64'(pkt_cnt0), 64'd1);
    end
    @(negedge clk);
    check("after_gap_tvalid", 64'(tvalid0), 64'd1);
    check("after_gap_tdata", 64'(tdata0), 64'd16);
    exp_word = 17;
    stream0(100, 1'b0, -1, 32);
    $display("[TB] basic: two packets streamed, pkt_cnt now %0d", pkt_cnt0);

    // Backpressure: tready toggling every cycle.
    reset0();
    en0 = 1'b1;
    exp_word = 0;
    stream0(200, 1'b1, -1, 16);
    @(negedge clk);
    check("bp_pkt_cnt", 64'(pkt_cnt0), 64'd1);
    $display("[TB] backpressure: 16 beats with stalls");

    // en drop at word 5: packet finishes, gap, then IDLE.
    reset0();
    tready0 = 1'b1;
    en0 = 1'b1;
    exp_word = 0;
    stream0(100, 1'b0, 5, 16);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check("drop_gap_tvalid", 64'(tvalid0), 64'd0);
    end
    @(negedge clk);
    check("drop_idle_busy", 64'(busy0), 64'd0);
    check("drop_idle_tvalid", 64'(tvalid0), 64'd0);
    check("drop_pkt_cnt", 64'(pkt_cnt0), 64'd1);
    repeat (3) @(negedge clk);
    check("drop_still_idle", 64'(tvalid0), 64'd0);
    en0 = 1'b1;
    @(negedge clk);
    check("resume_tvalid", 64'(tvalid0), 64'd1);
    check("resume_tdata", 64'(tdata0), 64'd16);
    check("resume_busy", 64'(busy0), 64'd1);
    exp_word = 17;
    stream0(100, 1'b0, -1, 23);
    $display("[TB] en drop: idle after packet, resumed at 16");

    // Reset while word 23 (beat index 7) is on the bus.
    @(negedge clk);
    check("mid_word", 64'(tdata0), 64'd23);
    res_n0 = 1'b0;
    @(negedge clk);
    check("mid_rst_tvalid", 64'(tvalid0), 64'd0);
    check("mid_rst_tdata", 64'(tdata0), 64'd0);
    check("mid_rst_pkt_cnt", 64'(pkt_cnt0), 64'd0);
    check("mid_rst_tlast", 64'(tlast0), 64'd0);
    check("mid_rst_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    res_n0 = 1'b1;
    exp_word = 0;
    stream0(20, 1'b0, -1, 3);
    $display("[TB] mid-packet reset: restarted at word 0");

    // GAP=0, PKT_LEN=1: 70000 back-to-back single-beat packets.
    res_n1 = 1'b1;
    en1 = 1'b1;
    tready1 = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      check("b2b_tvalid", 64'(tvalid1), 64'd1);
      check("b2b_tlast", 64'(tlast1), 64'd1);
      check("b2b_tdata", 64'(tdata1), 64'(i));
      if (i == 69999) en1 = 1'b0;
    end
    @(negedge clk);
    check("b2b_pkt_cnt", 64'(pkt_cnt1), 64'd4464);
    check("b2b_idle_tvalid", 64'(tvalid1), 64'd0);
    check("b2b_idle_busy", 64'(busy1), 64'd0);
    $display("[TB] gap0/len1: pkt_cnt %0d after 70000 beats", pkt_cnt1);

    // DATA_W=8: word 255 followed by 0, tlast alignment unchanged.
    res_n2 = 1'b1;
    en2 = 1'b1;
    tready2 = 1'b1;
    exp_word = 0;
    for (int c = 0; c < 400 && exp_word < 260; c++) begin
      @(negedge clk);
      if (tvalid2) begin
        check("wrap_tdata", 64'(tdata2), 64'(exp_word % 256));
        check("wrap_tlast", 64'(tlast2), 64'((exp_word % 16) == 15));
        exp_word++;
      end
    end
    check("wrap_count", 64'(exp_word), 64'd260);
    check("wrap_pkt_cnt", 64'(pkt_cnt2), 64'd16);
    $display("[TB] wrap: 8-bit counter passed 255 -> 0");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
